// File: rtl/pe_seq_datapath.sv
// Row-stationary PE with a built-in P x Q x S loop sequencer.
// Streams weights and an ifmap row into the scratchpads, runs the 1-D conv MAC
// loop, optionally adds upstream psums, then drains P psums over valid/ready.
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_start, i_cfg_*                     job start and config (latched on accepted start)
//   i_wght_*/o_wght_ready                weight stream in
//   i_ifmap_*/o_ifmap_ready              ifmap stream in
//   i_psum_data/_valid, o_psum_ready     upstream psum stream in
//   o_psum_data/_valid, i_psum_ready     psum stream out
//   o_busy, o_done, o_cfg_err            status
module pe_seq_datapath #(
  parameter int unsigned DATA_BITWIDTH       = 16,
  parameter int unsigned IFMAP_ADDR_BITWIDTH = 4,
  parameter int unsigned WGHT_ADDR_BITWIDTH  = 7,
  parameter int unsigned PSUM_ADDR_BITWIDTH  = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [PSUM_ADDR_BITWIDTH:0]    i_cfg_p,
  input  logic [IFMAP_ADDR_BITWIDTH:0]   i_cfg_q,
  input  logic [IFMAP_ADDR_BITWIDTH:0]   i_cfg_s,
  input  logic                           i_cfg_keep_wght,
  input  logic                           i_cfg_acc_en,
  input  logic [DATA_BITWIDTH-1:0]       i_ifmap_data,
  input  logic                           i_ifmap_valid,
  output logic                           o_ifmap_ready,
  input  logic [DATA_BITWIDTH-1:0]       i_wght_data,
  input  logic                           i_wght_valid,
  output logic                           o_wght_ready,
  input  logic [DATA_BITWIDTH-1:0]       i_psum_data,
  input  logic                           i_psum_valid,
  output logic                           o_psum_ready,
  output logic [DATA_BITWIDTH-1:0]       o_psum_data,
  output logic                           o_psum_valid,
  input  logic                           i_psum_ready,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_cfg_err
);

  localparam int unsigned DW      = DATA_BITWIDTH;
  localparam int unsigned IA      = IFMAP_ADDR_BITWIDTH;
  localparam int unsigned WA      = WGHT_ADDR_BITWIDTH;
  localparam int unsigned PA      = PSUM_ADDR_BITWIDTH;
  localparam int unsigned PW      = PA + 1;
  localparam int unsigned IW      = IA + 1;
  localparam int unsigned CW      = WA + 1;
  localparam int unsigned QSW     = 2 * IW;
  localparam int unsigned PQSW    = PW + QSW;
  localparam int unsigned I_DEPTH = 2 ** IA;
  localparam int unsigned W_DEPTH = 2 ** WA;
  localparam int unsigned P_DEPTH = 2 ** PA;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_I, S_COMPUTE, S_ACC, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] wght_spad  [W_DEPTH];
  logic [DW-1:0] ifmap_spad [I_DEPTH];
  logic [DW-1:0] psum_q     [P_DEPTH];
  logic [DW-1:0] psum_d     [P_DEPTH];

  logic [PW-1:0] p_r, p_idx;
  logic [IW-1:0] q_r, s_r, q_idx, s_idx;
  logic          acc_r;
  logic [CW-1:0] k_q;

  // Start-time config check on the raw inputs, at full product width
  logic [QSW-1:0]  cfg_qs;
  logic [PQSW-1:0] cfg_pqs;
  logic            cfg_ok, start_ok;
  assign cfg_qs   = QSW'(i_cfg_q) * QSW'(i_cfg_s);
  assign cfg_pqs  = PQSW'(i_cfg_p) * PQSW'(cfg_qs);
  assign cfg_ok   = (i_cfg_p != '0) && (i_cfg_q != '0) && (i_cfg_s != '0) &&
                    (i_cfg_p <= PW'(P_DEPTH)) && (cfg_qs <= QSW'(I_DEPTH)) &&
                    (cfg_pqs <= PQSW'(W_DEPTH));
  assign start_ok = (state_q == S_IDLE) && i_start && cfg_ok;

  // Phase lengths from latched config; products fit CW bits once config passed
  logic [CW-1:0] qs_c, pqs_c;
  assign qs_c  = CW'(q_r) * CW'(s_r);
  assign pqs_c = CW'(p_r) * qs_c;

  logic w_xfer, i_xfer, a_xfer, d_xfer;
  assign w_xfer = i_wght_valid  && o_wght_ready;
  assign i_xfer = i_ifmap_valid && o_ifmap_ready;
  assign a_xfer = i_psum_valid  && o_psum_ready;
  assign d_xfer = o_psum_valid  && i_psum_ready;

  logic last_w, last_i, last_p;
  assign last_w = (k_q == pqs_c - CW'(1));
  assign last_i = (k_q == qs_c - CW'(1));
  assign last_p = (k_q == CW'(p_r) - CW'(1));

  // MAC loop: q outer, s mid, p inner
  logic lp_p, lp_s, lp_q, mac_last, mac_first;
  assign lp_p      = (p_idx == p_r - PW'(1));
  assign lp_s      = (s_idx == s_r - IW'(1));
  assign lp_q      = (q_idx == q_r - IW'(1));
  assign mac_last  = lp_p && lp_s && lp_q;
  assign mac_first = (q_idx == '0) && (s_idx == '0);

  logic [IA-1:0] i_addr;
  logic [WA-1:0] w_addr;
  logic [DW-1:0] ifmap_rd, wght_rd, mac_prod, mac_sum;
  assign i_addr   = IA'(q_idx) * IA'(s_r) + IA'(s_idx);
  assign w_addr   = WA'(p_idx) * WA'(q_r) * WA'(s_r) + WA'(i_addr);
  assign ifmap_rd = ifmap_spad[i_addr];
  assign wght_rd  = wght_spad[w_addr];
  assign mac_prod = DW'($signed(ifmap_rd) * $signed(wght_rd));
  assign mac_sum  = (mac_first ? '0 : psum_q[p_idx[PA-1:0]]) + mac_prod;

  // Next state and next psum spad contents
  always_comb begin
    state_d = state_q;
    psum_d  = psum_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = i_cfg_keep_wght ? S_LOAD_I : S_LOAD_W;
      S_LOAD_W:  if (w_xfer && last_w) state_d = S_LOAD_I;
      S_LOAD_I:  if (i_xfer && last_i) state_d = S_COMPUTE;
      S_COMPUTE: begin
        psum_d[p_idx[PA-1:0]] = mac_sum;
        if (mac_last) state_d = acc_r ? S_ACC : S_DRAIN;
      end
      S_ACC: begin
        if (a_xfer) begin
          psum_d[k_q[PA-1:0]] = psum_q[k_q[PA-1:0]] + i_psum_data;
          if (last_p) state_d = S_DRAIN;
        end
      end
      S_DRAIN:   if (d_xfer && last_p) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, config, counters, psum spad and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < int'(P_DEPTH); i++) psum_q[i] <= '0;
      p_r           <= '0;
      q_r           <= '0;
      s_r           <= '0;
      acc_r         <= 1'b0;
      k_q           <= '0;
      p_idx         <= '0;
      q_idx         <= '0;
      s_idx         <= '0;
      o_wght_ready  <= 1'b0;
      o_ifmap_ready <= 1'b0;
      o_psum_ready  <= 1'b0;
      o_psum_valid  <= 1'b0;
      o_psum_data   <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      psum_q  <= psum_d;

      if (start_ok) begin
        p_r   <= i_cfg_p;
        q_r   <= i_cfg_q;
        s_r   <= i_cfg_s;
        acc_r <= i_cfg_acc_en;
        k_q   <= '0;
        p_idx <= '0;
        q_idx <= '0;
        s_idx <= '0;
      end

      case (state_q)
        S_LOAD_W: if (w_xfer) k_q <= last_w ? '0 : k_q + CW'(1);
        S_LOAD_I: if (i_xfer) k_q <= last_i ? '0 : k_q + CW'(1);
        S_ACC:    if (a_xfer) k_q <= last_p ? '0 : k_q + CW'(1);
        S_DRAIN:  if (d_xfer) k_q <= last_p ? '0 : k_q + CW'(1);
        S_COMPUTE: begin
          if (lp_p) begin
            p_idx <= '0;
            if (lp_s) begin
              s_idx <= '0;
              q_idx <= lp_q ? '0 : q_idx + IW'(1);
            end else begin
              s_idx <= s_idx + IW'(1);
            end
          end else begin
            p_idx <= p_idx + PW'(1);
          end
        end
        default: ;
      endcase

      o_wght_ready  <= (state_d == S_LOAD_W);
      o_ifmap_ready <= (state_d == S_LOAD_I);
      o_psum_ready  <= (state_d == S_ACC);
      o_busy        <= (state_d != S_IDLE);
      o_done        <= (state_q == S_DRAIN) && d_xfer && last_p;
      o_cfg_err     <= (state_q == S_IDLE) && i_start && !cfg_ok;

      // Output word taken from next-state spad so a final write is not missed
      if (state_d == S_DRAIN && state_q != S_DRAIN) begin
        o_psum_valid <= 1'b1;
        o_psum_data  <= psum_d[0];
      end else if (state_q == S_DRAIN && d_xfer) begin
        if (last_p) begin
          o_psum_valid <= 1'b0;
          o_psum_data  <= '0;
        end else begin
          o_psum_data  <= psum_d[PA'(k_q + CW'(1))];
        end
      end
    end
  end

  // Weight and ifmap spads: plain flop arrays, contents undefined after reset
  always_ff @(posedge i_clk) begin
    if (state_q == S_LOAD_W && w_xfer) wght_spad[k_q[WA-1:0]] <= i_wght_data;
    if (state_q == S_LOAD_I && i_xfer) ifmap_spad[k_q[IA-1:0]] <= i_ifmap_data;
  end

endmodule

// File: tb/tb_pe_seq_datapath.sv
// Self-checking bench for pe_seq_datapath: directed jobs, a loop-level
// reference model, and a negedge monitor that checks every drained word.
module tb_pe_seq_datapath;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [3:0]  i_cfg_p;
  logic [4:0]  i_cfg_q, i_cfg_s;
  logic        i_cfg_keep_wght, i_cfg_acc_en;
  logic [15:0] i_ifmap_data, i_wght_data, i_psum_data;
  logic        i_ifmap_valid, i_wght_valid, i_psum_valid;
  logic        o_ifmap_ready, o_wght_ready, o_psum_ready;
  logic [15:0] o_psum_data;
  logic        o_psum_valid, i_psum_ready;
  logic        o_busy, o_done, o_cfg_err;

  always #5 i_clk = ~i_clk;

  pe_seq_datapath dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_cfg_p(i_cfg_p), .i_cfg_q(i_cfg_q), .i_cfg_s(i_cfg_s),
    .i_cfg_keep_wght(i_cfg_keep_wght), .i_cfg_acc_en(i_cfg_acc_en),
    .i_ifmap_data(i_ifmap_data), .i_ifmap_valid(i_ifmap_valid), .o_ifmap_ready(o_ifmap_ready),
    .i_wght_data(i_wght_data), .i_wght_valid(i_wght_valid), .o_wght_ready(o_wght_ready),
    .i_psum_data(i_psum_data), .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
    .o_psum_data(o_psum_data), .o_psum_valid(o_psum_valid), .i_psum_ready(i_psum_ready),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what has been streamed in, and outputs still owed
  int          wm [128];
  int          im [16];
  int          up [8];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];

  int          comp_cnt, done_cnt;
  bit          wght_seen, sink_gaps;
  bit          hold_pend;
  logic [15:0] hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output sink: ready optionally toggles
  always @(posedge i_clk) begin
    #1;
    i_psum_ready = sink_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: drained data against model, stall stability, cycle accounting
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_busy && !o_wght_ready && !o_ifmap_ready && !o_psum_ready && !o_psum_valid)
        comp_cnt++;
      if (o_wght_ready) wght_seen = 1'b1;
      if (o_done) done_cnt++;
      if (hold_pend) begin
        chk("stall_valid", 32'(o_psum_valid), 32'd1);
        chk("stall_data", 32'(o_psum_data), 32'(hold_data));
      end
      if (o_psum_valid && i_psum_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(o_psum_valid), 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("psum_out", 32'(o_psum_data), 32'(e));
          got_q.push_back(o_psum_data);
        end
      end
      hold_pend = o_psum_valid && !i_psum_ready;
      hold_data = o_psum_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic feed_w(input int n, input bit gaps);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_wght_valid = 1'b0; @(posedge i_clk); #1;
      end
      i_wght_valid = 1'b1; i_wght_data = 16'(wm[k]);
      t = 0;
      @(negedge i_clk);
      while (!o_wght_ready && t < 1000) begin t++; @(negedge i_clk); end
      if (!o_wght_ready) begin
        chk("wght_timeout", 32'(o_wght_ready), 32'd1); i_wght_valid = 1'b0; return;
      end
      @(posedge i_clk); #1;
    end
    i_wght_valid = 1'b0;
  endtask

  task automatic feed_i(input int n, input bit gaps);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_ifmap_valid = 1'b0; @(posedge i_clk); #1;
      end
      i_ifmap_valid = 1'b1; i_ifmap_data = 16'(im[k]);
      t = 0;
      @(negedge i_clk);
      while (!o_ifmap_ready && t < 1000) begin t++; @(negedge i_clk); end
      if (!o_ifmap_ready) begin
        chk("ifmap_timeout", 32'(o_ifmap_ready), 32'd1); i_ifmap_valid = 1'b0; return;
      end
      @(posedge i_clk); #1;
    end
    i_ifmap_valid = 1'b0;
  endtask

  task automatic feed_a(input int n, input bit gaps);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_psum_valid = 1'b0; @(posedge i_clk); #1;
      end
      i_psum_valid = 1'b1; i_psum_data = 16'(up[k]);
      t = 0;
      @(negedge i_clk);
      while (!o_psum_ready && t < 1000) begin t++; @(negedge i_clk); end
      if (!o_psum_ready) begin
        chk("psum_in_timeout", 32'(o_psum_ready), 32'd1); i_psum_valid = 1'b0; return;
      end
      @(posedge i_clk); #1;
    end
    i_psum_valid = 1'b0;
  endtask

  task automatic reset_pulse(input string name);
    i_rst_n = 1'b0;
    #1;
    chk(name, 32'({o_ifmap_ready, o_wght_ready, o_psum_ready, o_psum_valid,
                   o_psum_data, o_busy, o_done, o_cfg_err}), 32'd0);
    exp_q.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  // abort: 0 run to completion, 1 reset mid COMPUTE, 2 reset mid DRAIN
  task automatic run_job(input int p, input int q, input int s, input bit keep,
                         input bit acc, input bit gaps, input int lit, input int abort);
    int          sum, t, d0;
    logic [15:0] e;
    for (int pp = 0; pp < p; pp++) begin
      sum = 0;
      for (int qq = 0; qq < q; qq++)
        for (int ss = 0; ss < s; ss++)
          sum += im[qq*s + ss] * wm[pp*q*s + qq*s + ss];
      if (acc) sum += up[pp];
      e = 16'(sum);
      exp_q.push_back(e);
    end
    got_q.delete();
    comp_cnt = 0; wght_seen = 1'b0; sink_gaps = gaps; d0 = done_cnt;

    @(posedge i_clk); #1;
    i_cfg_p = 4'(p); i_cfg_q = 5'(q); i_cfg_s = 5'(s);
    i_cfg_keep_wght = keep; i_cfg_acc_en = acc; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_cfg_p = 4'd0; i_cfg_q = 5'd0; i_cfg_s = 5'd0;
    fork
      if (!keep) feed_w(p*q*s, gaps);
      feed_i(q*s, gaps);
      if (acc) feed_a(p, gaps);
    join

    if (abort == 1) begin
      repeat (3) @(posedge i_clk);
      #3;
      reset_pulse("reset_mid_compute");
    end else if (abort == 2) begin
      t = 0;
      @(negedge i_clk);
      while (!o_psum_valid && t < 2000) begin t++; @(negedge i_clk); end
      chk("drain_reached", 32'(o_psum_valid), 32'd1);
      #2;
      reset_pulse("reset_mid_drain");
    end else begin
      t = 0;
      while (done_cnt == d0 && t < 3000) begin t++; @(negedge i_clk); end
      repeat (3) @(negedge i_clk);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("outputs_owed", 32'(exp_q.size()), 32'd0);
      chk("outputs_got", 32'(got_q.size()), 32'(p));
      chk("compute_cycles", 32'(comp_cnt), 32'(p*q*s));
      chk("busy_after_done", 32'(o_busy), 32'd0);
      if (keep) chk("wght_ready_seen", 32'(wght_seen), 32'd0);
      if (lit >= 0)
        foreach (got_q[i]) chk("literal_out", 32'(got_q[i]), 32'(lit));
    end
  endtask

  task automatic bad_cfg(input int p, input int q, input int s, input string name);
    @(posedge i_clk); #1;
    i_cfg_p = 4'(p); i_cfg_q = 5'(q); i_cfg_s = 5'(s); i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    chk(name, 32'(o_cfg_err), 32'd1);
    chk("cfg_err_quiet", 32'({o_busy, o_wght_ready, o_ifmap_ready, o_psum_ready}), 32'd0);
    @(negedge i_clk);
    chk("cfg_err_pulse_end", 32'({o_cfg_err, o_busy, o_wght_ready, o_ifmap_ready}), 32'd0);
  endtask

  task automatic load_job1();
    for (int k = 0; k < 12; k++) im[k] = k % 3 + 1;
    for (int k = 0; k < 72; k++) wm[k] = k % 3 + 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0;
    i_cfg_p = '0; i_cfg_q = '0; i_cfg_s = '0; i_cfg_keep_wght = 1'b0; i_cfg_acc_en = 1'b0;
    i_ifmap_data = '0; i_wght_data = '0; i_psum_data = '0;
    i_ifmap_valid = 1'b0; i_wght_valid = 1'b0; i_psum_valid = 1'b0;
    i_psum_ready = 1'b0; sink_gaps = 1'b0; done_cnt = 0; comp_cnt = 0;
    hold_pend = 1'b0; hold_data = '0; wght_seen = 1'b0;
    for (int k = 0; k < 128; k++) wm[k] = 0;
    for (int k = 0; k < 16; k++) im[k] = 0;
    for (int k = 0; k < 8; k++) up[k] = 10;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outputs", 32'({o_ifmap_ready, o_wght_ready, o_psum_ready, o_psum_valid,
                              o_psum_data, o_busy, o_done, o_cfg_err}), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Basic job: every filter sums to 4*(1+4+9)=56
    load_job1();
    run_job(6, 4, 3, 1'b0, 1'b0, 1'b0, 56, 0);
    // Upstream psums of 10 added
    run_job(6, 4, 3, 1'b0, 1'b1, 1'b0, 66, 0);
    // Reused weights, ifmap all 2: 2*4*(1+2+3)=48
    for (int k = 0; k < 12; k++) im[k] = 2;
    run_job(6, 4, 3, 1'b1, 1'b0, 1'b0, 48, 0);

    // Valid gaps and toggling output ready
    load_job1();
    run_job(6, 4, 3, 1'b0, 1'b0, 1'b1, 56, 0);
    run_job(6, 4, 3, 1'b0, 1'b1, 1'b1, 66, 0);

    // Wraparound arithmetic
    im[0] = 32'h7FFF; wm[0] = 2;
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b0, 32'hFFFE, 0);
    im[0] = -3; wm[0] = 5;
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b0, 32'hFFF1, 0);

    // Rejected configurations
    bad_cfg(0, 4, 3, "cfg_err_p0");
    bad_cfg(1, 5, 4, "cfg_err_qs20");

    // Reset mid COMPUTE and mid DRAIN, then a clean job
    load_job1();
    run_job(6, 4, 3, 1'b0, 1'b0, 1'b0, -1, 1);
    run_job(6, 4, 3, 1'b0, 1'b0, 1'b0, -1, 2);
    run_job(6, 4, 3, 1'b0, 1'b0, 1'b0, 56, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
